// File: rtl/posit_pkg.sv
// Shared posit constants and field bundle for the encoder and the positadd decode side.
package posit_pkg;

  localparam int unsigned POSIT_N  = 32;
  localparam int unsigned POSIT_ES = 2;
  localparam int unsigned POSIT_FW = 30;
  localparam int unsigned POSIT_SW = 9;

  localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] MINPOS = POSIT_N'(1);
  localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};

  // Smallest scale that no longer fits a regime inside n-1 bits.
  function automatic int max_scale(input int unsigned n, input int unsigned es);
    return int'((n - 2) << es);
  endfunction

  localparam int MAX_SCALE = max_scale(POSIT_N, POSIT_ES);

  typedef struct packed {
    logic                sign;
    logic [POSIT_SW-1:0] scale;
    logic [POSIT_FW-1:0] frac;
    logic                sticky;
    logic                zero;
    logic                inf;
  } posit_fields_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of a posit magnitude; never wraps past maxpos or drops to zero.
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int unsigned MW = POSIT_N - 1
) (
  input  logic [MW-1:0] mag_i,
  input  logic          guard_i,
  input  logic          sticky_i,
  output logic [MW-1:0] mag_c_o
);

  logic round_up_c;

  always_comb begin
    round_up_c = guard_i && (mag_i[0] || sticky_i);
    mag_c_o    = mag_i;
    if (round_up_c && !(&mag_i)) begin
      mag_c_o = mag_i + MW'(1);
    end
    if (mag_c_o == '0) begin
      mag_c_o = MW'(1);
    end
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: field split, pack/round, sign/specials, with valid/ready.
// Optional saturation counter port sat_count under POSIT_ENC_SAT_CNT_EN.
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int unsigned N  = POSIT_N,
  parameter int unsigned ES = POSIT_ES,
  parameter int unsigned FW = POSIT_FW,
  parameter int unsigned SW = POSIT_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_zero,
  output logic          out_inf
`ifdef POSIT_ENC_SAT_CNT_EN
  ,
  output logic [15:0]   sat_count
`endif
);

  localparam int unsigned MW   = N - 1;
  localparam int unsigned VW   = 2 + ES + FW;
  localparam int unsigned EXTW = VW + N - 3;
  localparam int unsigned SHW  = $clog2(N);
  localparam logic signed [SW-1:0] SAT_HI = SW'(max_scale(N, ES));
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

  logic s1_v_q, s2_v_q, s3_v_q;
  logic s1_adv_c, s2_adv_c, s3_adv_c;

  assign s3_adv_c  = !s3_v_q || out_ready;
  assign s2_adv_c  = !s2_v_q || s3_adv_c;
  assign s1_adv_c  = !s1_v_q || s2_adv_c;
  assign in_ready  = !s1_v_q || s1_adv_c;
  assign out_valid = s3_v_q;

  // ---------------- S1: regime shift amount and saturation detect
  logic signed [SW-1:0] scale_c, k_c;
  logic                 s1_smax_d, s1_smin_d, s1_neg_d;
  logic [SHW-1:0]       s1_sh_d;

  logic           s1_sign_q, s1_zero_q, s1_inf_q, s1_smax_q, s1_smin_q, s1_neg_q, s1_stk_q;
  logic [SHW-1:0] s1_sh_q;
  logic [ES-1:0]  s1_e_q;
  logic [FW-1:0]  s1_frac_q;

  assign scale_c = $signed(in_scale);
  assign k_c     = scale_c >>> ES;

  always_comb begin
    s1_smax_d = scale_c >= SAT_HI;
    s1_smin_d = scale_c <= SAT_LO;
    s1_neg_d  = k_c[SW-1];
    // Fill run beyond the two-bit regime seed: k ones for k>=0, -k-1 zeros for k<0.
    s1_sh_d   = k_c[SW-1] ? SHW'(~k_c) : SHW'(k_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_inf_q  <= 1'b0;
      s1_smax_q <= 1'b0;
      s1_smin_q <= 1'b0;
      s1_neg_q  <= 1'b0;
      s1_stk_q  <= 1'b0;
      s1_sh_q   <= '0;
      s1_e_q    <= '0;
      s1_frac_q <= '0;
    end else if (s1_adv_c) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_zero_q <= in_zero;
        s1_inf_q  <= in_inf;
        s1_smax_q <= s1_smax_d;
        s1_smin_q <= s1_smin_d;
        s1_neg_q  <= s1_neg_d;
        s1_stk_q  <= in_sticky;
        s1_sh_q   <= s1_sh_d;
        s1_e_q    <= in_scale[ES-1:0];
        s1_frac_q <= in_frac;
      end
    end
  end

  // ---------------- S2: pack regime|e|frac, round, apply saturation
  logic [VW-1:0]   seed_c;
  logic [EXTW-1:0] ext_c, fill_c, shifted_c;
  logic [MW-1:0]   mag_pre_c, mag_rnd_c, s2_mag_d;
  logic            guard_c, sticky_c;

  logic          s2_sign_q, s2_zero_q, s2_inf_q;
  logic [MW-1:0] s2_mag_q;

  assign seed_c    = {~s1_neg_q, s1_neg_q, s1_e_q, s1_frac_q};
  assign ext_c     = {seed_c, {(N-3){1'b0}}};
  assign fill_c    = s1_neg_q ? '0 : ~({EXTW{1'b1}} >> s1_sh_q);
  assign shifted_c = (ext_c >> s1_sh_q) | fill_c;
  assign mag_pre_c = shifted_c[EXTW-1 -: MW];
  assign guard_c   = shifted_c[EXTW-1-MW];
  assign sticky_c  = (|shifted_c[EXTW-2-MW:0]) | s1_stk_q;

  posit_round_rne #(.MW(MW)) u_round (
    .mag_i   (mag_pre_c),
    .guard_i (guard_c),
    .sticky_i(sticky_c),
    .mag_c_o (mag_rnd_c)
  );

  always_comb begin
    s2_mag_d = mag_rnd_c;
    if (s1_smax_q) begin
      s2_mag_d = {MW{1'b1}};
    end else if (s1_smin_q) begin
      s2_mag_d = MW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_inf_q  <= 1'b0;
      s2_mag_q  <= '0;
    end else if (s2_adv_c) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_inf_q  <= s1_inf_q;
        s2_mag_q  <= s2_mag_d;
      end
    end
  end

  // ---------------- S3: sign, specials, output register
  logic [N-1:0] posit_d;

  always_comb begin
    posit_d = {1'b0, s2_mag_q};
    if (s2_inf_q) begin
      posit_d = {1'b1, {(N-1){1'b0}}};
    end else if (s2_zero_q) begin
      posit_d = '0;
    end else if (s2_sign_q) begin
      posit_d = ~{1'b0, s2_mag_q} + N'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v_q    <= 1'b0;
      out_posit <= '0;
      out_zero  <= 1'b0;
      out_inf   <= 1'b0;
    end else if (s3_adv_c) begin
      s3_v_q <= s2_v_q;
      if (s2_v_q) begin
        out_posit <= posit_d;
        out_zero  <= s2_inf_q ? 1'b0 : s2_zero_q;
        out_inf   <= s2_inf_q;
      end
    end
  end

`ifdef POSIT_ENC_SAT_CNT_EN
  // Clamp flag rides alongside the beat; specials never count.
  logic s2_clamp_d, s2_clamp_q, s3_clamp_q;

  assign s2_clamp_d = !s1_zero_q && !s1_inf_q &&
                      (s1_smax_q || s1_smin_q || ((&mag_pre_c) && guard_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_clamp_q <= 1'b0;
      s3_clamp_q <= 1'b0;
      sat_count  <= '0;
    end else begin
      if (s2_adv_c && s1_v_q) begin
        s2_clamp_q <= s2_clamp_d;
      end
      if (s3_adv_c && s2_v_q) begin
        s3_clamp_q <= s2_clamp_q;
      end
      if (s3_v_q && out_ready && s3_clamp_q && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Bench for posit_encode_pipe: bit-string posit model, scoreboard monitor, directed vectors.
module tb_posit_encode_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_scale;
  logic [29:0] in_frac;
  logic        in_sticky;
  logic        in_zero;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;
  logic        out_zero;
  logic        out_inf;
`ifdef POSIT_ENC_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  posit_encode_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_scale (in_scale),
    .in_frac  (in_frac),
    .in_sticky(in_sticky),
    .in_zero  (in_zero),
    .in_inf   (in_inf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_posit(out_posit),
    .out_zero (out_zero),
    .out_inf  (out_inf)
`ifdef POSIT_ENC_SAT_CNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] posit;
    bit          zero;
    bit          inf;
    bit          clamp;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          sat_m  = 0;
  bit          held   = 0;
  logic [31:0] held_posit;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Posit value model: write the regime/exponent/fraction bits out, cut to 31, round RNE.
  function automatic exp_t model(input bit s, input int sc, input logic [29:0] f,
                                 input bit st, input bit z, input bit i);
    exp_t    r;
    int      k, e;
    bit      bits[$];
    longint  mag;
    bit      g, stk;
    logic [31:0] m32;
    r.zero = 0; r.inf = 0; r.clamp = 0;
    if (i) begin r.posit = 32'h8000_0000; r.inf = 1; return r; end
    if (z) begin r.posit = 32'h0; r.zero = 1; return r; end
    if (sc >= 120) begin
      mag = 64'h7FFF_FFFF; r.clamp = 1;
    end else if (sc <= -120) begin
      mag = 1; r.clamp = 1;
    end else begin
      k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
      e = sc - 4 * k;
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(e[1]);
      bits.push_back(e[0]);
      for (int b = 29; b >= 0; b--) bits.push_back(f[b]);
      mag = 0;
      for (int b = 0; b < 31; b++) mag = (mag << 1) | longint'(bits[b]);
      g   = bits[31];
      stk = st;
      for (int b = 32; b < bits.size(); b++) stk |= bits[b];
      if (g && ((mag % 2) == 1 || stk)) begin
        if (mag == 64'h7FFF_FFFF) r.clamp = 1;
        else mag = mag + 1;
      end
      if (mag == 0) mag = 1;
    end
    m32 = mag[31:0];
    r.posit = s ? (~m32 + 32'd1) : m32;
    return r;
  endfunction

  // Scoreboard: ordering, content, stall stability, back-pressure, saturation count.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held  = 0;
      sat_m = 0;
    end else begin
      if (!in_ready) chk("in_ready_low_only_when_full", 32'(q.size()), 32'd3);
`ifdef POSIT_ENC_SAT_CNT_EN
      chk("sat_count_model", 32'(sat_count), 32'(sat_m));
`endif
      if (out_valid) begin
        if (held) chk("stall_stable", out_posit, held_posit);
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          chk("out_posit", out_posit, q[0].posit);
          chk("out_zero", 32'(out_zero), 32'(q[0].zero));
          chk("out_inf", 32'(out_inf), 32'(q[0].inf));
          if (out_ready) begin
            if (q[0].clamp) sat_m++;
            void'(q.pop_front());
          end
        end
        held       = !out_ready;
        held_posit = out_posit;
      end else begin
        held = 0;
      end
      if (in_valid && in_ready)
        q.push_back(model(in_sign, int'($signed(in_scale)), in_frac, in_sticky, in_zero, in_inf));
    end
  end

  // Present one beat and hold it until accepted; caller is just after a rising edge.
  task automatic drive(input bit s, input int sc, input logic [29:0] f, input bit st,
                       input bit z, input bit i, output int stalls);
    in_valid  = 1'b1;
    in_sign   = s;
    in_scale  = 9'(sc);
    in_frac   = f;
    in_sticky = st;
    in_zero   = z;
    in_inf    = i;
    stalls    = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) chk("drive_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string nm, input bit s, input int sc, input logic [29:0] f,
                        input bit st, input bit z, input bit i,
                        input logic [31:0] exp, input bit ez, input bit ei);
    int stalls;
    drive(s, sc, f, st, z, i, stalls);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk(nm, out_posit, exp);
    chk({nm, "_zero"}, 32'(out_zero), 32'(ez));
    chk({nm, "_inf"}, 32'(out_inf), 32'(ei));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  int          sc_tab[8] = '{3, -5, 17, -40, 100, -100, 0, 7};
  logic [29:0] fr_tab[8] = '{30'h2AAA_AAAA, 30'h1555_5555, 30'h0000_0004, 30'h3FFF_FFFF,
                             30'h0123_4567, 30'h3000_0000, 30'h0000_0006, 30'h0F0F_0F0F};
  bit   [3:0]  rdy_pat   = 4'b1001;

  initial begin
    exp_t m;
    int   stalls;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_scale = '0; in_frac = '0;
    in_sticky = 1'b0; in_zero = 1'b0; in_inf = 1'b0; out_ready = 1'b1;

    m = model(0, 0, 30'h0, 0, 0, 0);          chk("pin_one", m.posit, 32'h4000_0000);
    m = model(0, 1, 30'h0, 0, 0, 0);          chk("pin_scale1", m.posit, 32'h4800_0000);
    m = model(0, -1, 30'h0, 0, 0, 0);         chk("pin_scale_m1", m.posit, 32'h3800_0000);
    m = model(1, 0, 30'h0, 0, 0, 0);          chk("pin_neg_one", m.posit, 32'hC000_0000);
    m = model(0, 0, 30'h4, 1, 0, 0);          chk("pin_round_up", m.posit, 32'h4000_0001);
    m = model(0, 200, 30'h0, 0, 0, 0);        chk("pin_maxpos_clamp", 32'(m.clamp), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_posit", out_posit, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    single("one",        0,    0, 30'h0, 0, 0, 0, 32'h4000_0000, 0, 0);
    single("scale1",     0,    1, 30'h0, 0, 0, 0, 32'h4800_0000, 0, 0);
    single("scale4",     0,    4, 30'h0, 0, 0, 0, 32'h6000_0000, 0, 0);
    single("scale_m1",   0,   -1, 30'h0, 0, 0, 0, 32'h3800_0000, 0, 0);
    single("neg_one",    1,    0, 30'h0, 0, 0, 0, 32'hC000_0000, 0, 0);
    single("nar_prio",   0,    5, 30'h0, 0, 1, 1, 32'h8000_0000, 0, 1);
    single("zero",       1,    5, 30'h0, 0, 1, 0, 32'h0000_0000, 1, 0);
    single("maxpos",     0,  200, 30'h0, 0, 0, 0, 32'h7FFF_FFFF, 0, 0);
    single("minpos",     0, -200, 30'h0, 0, 0, 0, 32'h0000_0001, 0, 0);
`ifdef POSIT_ENC_SAT_CNT_EN
    chk("sat_count_two", 32'(sat_count), 32'd2);
`endif
    single("tie_even",   0,    0, 30'h4, 0, 0, 0, 32'h4000_0000, 0, 0);
    single("tie_sticky", 0,    0, 30'h4, 1, 0, 0, 32'h4000_0001, 0, 0);
    single("near_max",   0,  119, 30'h0, 0, 0, 0, 32'h7FFF_FFFF, 0, 0);
    single("near_min",   0, -119, 30'h0, 0, 0, 0, 32'h0000_0001, 0, 0);
    single("neg_minpos", 1, -200, 30'h0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);

    // Back-to-back with out_ready held high: no bubbles.
    for (int b = 0; b < 4; b++) begin
      drive(b[0], sc_tab[b], fr_tab[b], 0, 0, 0, stalls);
      chk("full_rate_no_stall", 32'(stalls), 32'd0);
    end
    in_valid = 1'b0;
    drain();

    // Eight beats against out_ready 1,0,0,1.
    fork
      begin
        for (int b = 0; b < 8; b++) drive(b[1], sc_tab[b], fr_tab[b], b[2], 0, 0, stalls);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = rdy_pat[c % 4];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Fill all three stages, then reset mid-flight.
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) drive(0, b, 30'h0, 0, 0, 0, stalls);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("full_ready_low", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_posit", out_posit, 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("ready_after_mid_reset", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_beat", 32'(out_valid), 32'd0);
    single("post_reset", 0, 4, 30'h0, 0, 0, 0, 32'h6000_0000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
